// File: rtl/crc_stream_if.sv
// Byte-stream input and CRC-result output channel of the CRC stream engine.
// The slave modport is the engine's view; master is the producer/consumer side.
interface crc_stream_if #(
  parameter int unsigned BITS = 8
) ();
  logic            s_valid;
  logic            s_ready;
  logic [7:0]      s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [BITS-1:0] m_crc;
  logic [15:0]     m_len;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_crc, m_len
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_crc, m_len
  );
endinterface

// File: rtl/crc_stream_engine.sv
// Parameterised streaming CRC: one byte per cycle, result held with a valid/ready
// handshake together with the frame length.
module crc_stream_engine #(
  parameter int unsigned     BITS   = 8,
  parameter logic [BITS-1:0] POLY   = BITS'(8'h07),
  parameter logic [BITS-1:0] INIT   = '0,
  parameter bit              REFIN  = 1'b0,
  parameter bit              REFOUT = 1'b0,
  parameter logic [BITS-1:0] XOROUT = '0
) (
  input  logic         clk,
  input  logic         rst,
  crc_stream_if.slave  bus,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] crc_q, crc_d;
  logic [15:0]     len_q, len_d;
  logic [BITS-1:0] m_crc_q, m_crc_d;
  logic [15:0]     m_len_q, m_len_d;

  logic            accept;
  logic [7:0]      data_in;
  logic [BITS-1:0] crc_base;
  logic [BITS-1:0] crc_next;
  logic [15:0]     len_base;
  logic [15:0]     len_next;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [BITS-1:0] reflect_crc(input logic [BITS-1:0] c);
    logic [BITS-1:0] r;
    for (int i = 0; i < int'(BITS); i++) r[i] = c[int'(BITS)-1-i];
    return r;
  endfunction

  function automatic logic [BITS-1:0] crc_byte(input logic [BITS-1:0] c, input logic [7:0] d);
    logic [BITS-1:0] r;
    r = c ^ (BITS'(d) << (BITS - 8));
    for (int i = 0; i < 8; i++) begin
      if (r[BITS-1]) r = (r << 1) ^ POLY;
      else           r = r << 1;
    end
    return r;
  endfunction

  assign bus.s_ready = (state_q != StDone);
  assign bus.m_valid = (state_q == StDone);
  assign bus.m_crc   = m_crc_q;
  assign bus.m_len   = m_len_q;
  assign busy        = (state_q != StIdle);

  assign accept   = bus.s_valid && bus.s_ready;
  assign data_in  = REFIN ? reflect8(bus.s_data) : bus.s_data;
  // A frame's first byte always starts from INIT, never from the previous frame's register.
  assign crc_base = (state_q == StIdle) ? INIT : crc_q;
  assign crc_next = crc_byte(crc_base, data_in);
  assign len_base = (state_q == StIdle) ? 16'd0 : len_q;
  assign len_next = (len_base == 16'hFFFF) ? 16'hFFFF : len_base + 16'd1;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    m_crc_d = m_crc_q;
    m_len_d = m_len_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          crc_d = crc_next;
          len_d = len_next;
          if (bus.s_last) begin
            state_d = StDone;
            m_crc_d = (REFOUT ? reflect_crc(crc_next) : crc_next) ^ XOROUT;
            m_len_d = len_next;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StDone: begin
        if (bus.m_ready) begin
          state_d = StIdle;
          crc_d   = INIT;
          len_d   = 16'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      crc_q   <= INIT;
      len_q   <= 16'd0;
      m_crc_q <= '0;
      m_len_q <= 16'd0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      m_crc_q <= m_crc_d;
      m_len_q <= m_len_d;
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: CRC-8, CRC-16/CCITT-FALSE and CRC-32 instances
// share one stimulus bus; sel picks which instance is driven and observed.
module tb_crc_stream_engine;

  logic       clk;
  logic       rst;
  logic       v;
  logic [7:0] d;
  logic       l;
  logic       mr;
  logic [1:0] sel;

  logic        busy8, busy16, busy32;
  logic        rdy, mv, bsy;
  logic [63:0] crc;
  logic [15:0] len;

  int n_checks;
  int n_bad;

  crc_stream_if #(.BITS(8))  i8 ();
  crc_stream_if #(.BITS(16)) i16 ();
  crc_stream_if #(.BITS(32)) i32 ();

  crc_stream_engine u8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (i8),
    .busy (busy8)
  );

  crc_stream_engine #(
    .BITS (16),
    .POLY (16'h1021),
    .INIT (16'hFFFF)
  ) u16 (
    .clk  (clk),
    .rst  (rst),
    .bus  (i16),
    .busy (busy16)
  );

  crc_stream_engine #(
    .BITS   (32),
    .POLY   (32'h04C11DB7),
    .INIT   (32'hFFFFFFFF),
    .REFIN  (1'b1),
    .REFOUT (1'b1),
    .XOROUT (32'hFFFFFFFF)
  ) u32 (
    .clk  (clk),
    .rst  (rst),
    .bus  (i32),
    .busy (busy32)
  );

  assign i8.s_valid  = v && (sel == 2'd0);
  assign i8.s_data   = d;
  assign i8.s_last   = l;
  assign i8.m_ready  = mr && (sel == 2'd0);
  assign i16.s_valid = v && (sel == 2'd1);
  assign i16.s_data  = d;
  assign i16.s_last  = l;
  assign i16.m_ready = mr && (sel == 2'd1);
  assign i32.s_valid = v && (sel == 2'd2);
  assign i32.s_data  = d;
  assign i32.s_last  = l;
  assign i32.m_ready = mr && (sel == 2'd2);

  always_comb begin
    rdy = 1'b0;
    mv  = 1'b0;
    bsy = 1'b0;
    crc = '0;
    len = '0;
    case (sel)
      2'd0: begin
        rdy = i8.s_ready; mv = i8.m_valid; bsy = busy8;
        crc = 64'(i8.m_crc); len = i8.m_len;
      end
      2'd1: begin
        rdy = i16.s_ready; mv = i16.m_valid; bsy = busy16;
        crc = 64'(i16.m_crc); len = i16.m_len;
      end
      default: begin
        rdy = i32.s_ready; mv = i32.m_valid; bsy = busy32;
        crc = 64'(i32.m_crc); len = i32.m_len;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one byte after gap idle cycles; returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] data, input logic last, input int gap);
    int n;
    v = 1'b0;
    repeat (gap) @(negedge clk);
    v = 1'b1;
    d = data;
    l = last;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(rdy), 64'd1);
    if (rdy) @(negedge clk);
    v = 1'b0;
    l = 1'b0;
  endtask

  task automatic send_msg(input int gapmax);
    for (int i = 1; i <= 9; i++)
      send_byte(8'(48 + i), i == 9, (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
  endtask

  task automatic wait_result(input string tag, input logic [63:0] exp_crc,
                             input logic [15:0] exp_len);
    int n;
    n = 0;
    while (!mv && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(mv), 64'd1);
    check({tag, "_crc"}, crc, exp_crc);
    check({tag, "_len"}, 64'(len), 64'(exp_len));
    mr = 1'b1;
    @(negedge clk);
    mr = 1'b0;
    check({tag, "_drop"}, 64'(mv), 64'd0);
    check({tag, "_idle"}, 64'(bsy), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    rst = 1'b1;
    v   = 1'b0;
    d   = 8'h00;
    l   = 1'b0;
    mr  = 1'b0;
    sel = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 64'(rdy), 64'd1);
    check("rst_valid", 64'(mv), 64'd0);
    check("rst_crc", crc, 64'd0);
    check("rst_len", 64'(len), 64'd0);
    check("rst_busy", 64'(bsy), 64'd0);

    // CRC-8 "123456789", no stalls, result one cycle after the last accept
    for (int i = 1; i <= 8; i++) send_byte(8'(48 + i), 1'b0, 0);
    check("c8_busy", 64'(bsy), 64'd1);
    check("c8_early_valid", 64'(mv), 64'd0);
    send_byte(8'h39, 1'b1, 0);
    check("c8_latency", 64'(mv), 64'd1);
    wait_result("c8", 64'hF4, 16'd9);

    // Single-byte frames straight after a completed frame
    send_msg(0);
    wait_result("pre1", 64'hF4, 16'd9);
    send_byte(8'h00, 1'b1, 0);
    wait_result("one00", 64'h00, 16'd1);
    send_byte(8'h01, 1'b1, 0);
    wait_result("one01", 64'h07, 16'd1);

    // Result back-pressure with s_valid held high
    send_msg(0);
    v = 1'b1;
    d = 8'h31;
    l = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("stall_ready", 64'(rdy), 64'd0);
      check("stall_crc", crc, 64'hF4);
      check("stall_len", 64'(len), 64'd9);
      @(negedge clk);
    end
    mr = 1'b1;
    @(negedge clk);
    mr = 1'b0;
    check("stall_release", 64'(mv), 64'd0);
    send_msg(0);
    wait_result("stall_next", 64'hF4, 16'd9);

    // CRC-16/CCITT-FALSE with random input gaps
    sel = 2'd1;
    send_msg(3);
    wait_result("c16", 64'h29B1, 16'd9);

    // CRC-32 (reflected)
    sel = 2'd2;
    send_msg(2);
    wait_result("c32", 64'hCBF43926, 16'd9);

    // Mid-frame reset; a last byte offered in the reset cycle must be ignored
    sel = 2'd0;
    for (int i = 1; i <= 4; i++) send_byte(8'(48 + i), 1'b0, 0);
    v   = 1'b1;
    d   = 8'h35;
    l   = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v   = 1'b0;
    l   = 1'b0;
    check("abort_valid", 64'(mv), 64'd0);
    check("abort_len", 64'(len), 64'd0);
    check("abort_busy", 64'(bsy), 64'd0);
    check("abort_ready", 64'(rdy), 64'd1);
    repeat (3) @(negedge clk);
    check("abort_quiet", 64'(mv), 64'd0);
    send_msg(0);
    wait_result("after_rst", 64'hF4, 16'd9);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter BITS, default 8: CRC width; legal range 8..64.
REQ-002 The block SHALL have parameter POLY, default 'h07: generator polynomial, normal form, implicit top bit omitted, BITS wide.
REQ-003 The block SHALL have parameter INIT, default 'h00: register preset at frame start, BITS wide.
REQ-004 The block SHALL have parameter REFIN, default 0: when 1, each input byte is bit-reversed before processing.
REQ-005 The block SHALL have parameter REFOUT, default 0: when 1, the final register is bit-reversed across BITS before the output XOR.
REQ-006 The block SHALL have parameter XOROUT, default 'h00: value XORed onto the result, BITS wide.
Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port clk, input, 1: sole clock; all state on the rising edge.
REQ-008 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 The block SHALL have port s_valid, input, 1: an input byte is offered.
REQ-010 The block SHALL have port s_ready, output, 1: the block accepts a byte this cycle.
REQ-011 The block SHALL have port s_data, input, 8: message byte.
REQ-012 The block SHALL have port s_last, input, 1: the offered byte is the final byte of its frame.
REQ-013 The block SHALL have port m_valid, output, 1: result is valid.
REQ-014 The block SHALL have port m_ready, input, 1: the consumer takes the result.
REQ-015 The block SHALL have port m_crc, output, BITS: final CRC.
REQ-016 The block SHALL have port m_len, output, 16: byte count of the reported frame.
REQ-017 The block SHALL have port busy, output, 1: a frame is in progress or a result is pending.

Function
REQ-018 The block SHALL have FSM states IDLE, ACCUM and DONE; reset state is IDLE.
REQ-019 In IDLE and ACCUM, s_ready SHALL be 1; in DONE, s_ready SHALL be 0.
REQ-020 A byte SHALL be accepted on a rising edge only when s_valid and s_ready are both 1; s_data and s_last are ignored otherwise.
REQ-021 Per accepted byte, the register SHALL update in one cycle: optional REFIN reflect, XOR into the top 8 bits of the register, then 8 MSB-first shift/conditional-XOR-POLY steps, truncated to BITS.
REQ-022 A byte accepted in IDLE SHALL be processed against INIT, not the stale register, so back-to-back frames need no idle cycle.
REQ-023 IDLE -> ACCUM SHALL occur on an accept with s_last=0; IDLE or ACCUM -> DONE SHALL occur on an accept with s_last=1; ACCUM SHALL hold otherwise.
REQ-024 On entry to DONE, m_crc SHALL be loaded with the finalised register (REFOUT reflect, then XOR XOROUT), m_len with the frame byte count, and m_valid set to 1; latency is 1 cycle from the last-byte edge.
REQ-025 The length counter SHALL count accepted bytes per frame, start at 1 for the first byte, and saturate at 16'hFFFF without wrapping.
REQ-026 In DONE, m_valid, m_crc and m_len SHALL hold stable until m_ready=1, regardless of s_valid.
REQ-027 DONE -> IDLE SHALL occur on the edge where m_ready=1; m_valid drops next cycle, the register reloads INIT and the counter clears; the next byte is accepted the following cycle.
REQ-028 m_ready while m_valid=0 SHALL have no effect.
REQ-029 busy SHALL be 1 in ACCUM and DONE and 0 in IDLE.
REQ-030 A single-byte frame (s_last on the first byte) SHALL be legal and give m_len=1.
REQ-031 Mid-frame, s_valid=0 SHALL stall the computation with no state change.

Reset
REQ-032 While rst=1 at an edge, the block SHALL force: state IDLE, register INIT, counter 0, m_valid 0, m_crc 0, m_len 0; s_ready is 1 from the first cycle after reset.
REQ-033 Reset SHALL take priority over every accept and handshake in the same cycle.
REQ-034 After a mid-frame reset, the aborted partial frame SHALL never produce a result.

Verification
REQ-035 The bench SHALL cover: defaults, "123456789" with no stalls -> m_crc=8'hF4, m_len=9, m_valid one cycle after the last accept.
REQ-036 The bench SHALL cover: BITS=16, POLY=16'h1021, INIT=16'hFFFF, "123456789" with random s_valid gaps -> m_crc=16'h29B1.
REQ-037 The bench SHALL cover: BITS=32, POLY=32'h04C11DB7, INIT=XOROUT=32'hFFFFFFFF, REFIN=REFOUT=1, "123456789" -> m_crc=32'hCBF43926.
REQ-038 The bench SHALL cover: m_ready held 0 for 10 cycles with s_valid=1 -> s_ready=0, m_crc/m_len stable, no byte lost; next frame after release is correct.
REQ-039 The bench SHALL cover: defaults, single byte 8'h00 with s_last=1 immediately after a completed frame -> m_crc=8'h00, m_len=1.
REQ-040 The bench SHALL cover: rst pulsed after 4 bytes of a frame, then "123456789" sent -> 8'hF4, m_len=9, no result for the aborted frame.
